// File: rtl/serial_a_paralelo_idle_sync_if.sv
// Byte-side bundle of the IDLE-sync deserialiser: serial line in, aligned bytes and
// link status out.
interface serial_a_paralelo_idle_sync_if;
  logic       in_serial;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       comma_out;

  modport master (
    output in_serial,
    input  data_out,
    input  valid_out,
    input  active,
    input  comma_out
  );

  modport slave (
    input  in_serial,
    output data_out,
    output valid_out,
    output active,
    output comma_out
  );
endinterface

// File: rtl/serial_a_paralelo_idle_sync.sv
// Serial-to-byte receiver: hunts for the comma at any bit phase, confirms alignment
// over a run of commas, then delivers MSB-first bytes with one-cycle strobes.
module serial_a_paralelo_idle_sync #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic                          clk32f,
  input  logic                          reset,
  serial_a_paralelo_idle_sync_if.slave  bus
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_ALIGNED = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [3:0] LOCK_RUN = 4'(COMMA_COUNT);

  function automatic logic is_comma(input logic [7:0] b);
    return b == COMMA;
  endfunction

  // Only the 7 most recent bits are stored; the 8th is the bit on the line now.
  logic [6:0] sr_q,        sr_d;
  logic [1:0] state_q,     state_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q,      data_d;
  logic       valid_q,     valid_d;
  logic       active_q,    active_d;
  logic       comma_q,     comma_d;

  logic [7:0] byte_next;
  logic       boundary;
  logic       byte_is_comma;

  assign byte_next     = {sr_q, bus.in_serial};
  assign boundary      = (bit_cnt_q == 3'd7);
  assign byte_is_comma = is_comma(byte_next);

  always_comb begin
    sr_d        = byte_next[6:0];
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    active_d    = active_q;
    valid_d     = 1'b0;
    comma_d     = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (byte_is_comma) begin
          state_d     = ST_ALIGNED;
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
        end
      end

      ST_ALIGNED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (byte_is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == LOCK_RUN) begin
              state_d  = ST_LOCKED;
              active_d = 1'b1;
            end
          end else begin
            // The failing byte is not re-hunted; hunting resumes on the next bit.
            state_d     = ST_HUNT;
            comma_cnt_d = 4'd0;
            bit_cnt_d   = 3'd0;
          end
        end
      end

      ST_LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d = byte_next;
          if (byte_is_comma) begin
            comma_d = 1'b1;
          end else begin
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = ST_HUNT;
        bit_cnt_d   = 3'd0;
        comma_cnt_d = 4'd0;
        active_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      sr_q        <= 7'd0;
      state_q     <= ST_HUNT;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      comma_q     <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      comma_q     <= comma_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;
  assign bus.comma_out = comma_q;

endmodule

// File: tb/tb_serial_a_paralelo_idle_sync.sv
// Bench for the IDLE-sync deserialiser: bit-history reference model checked every
// cycle, plus directed alignment/lock scenarios with hand-computed expectations.
module tb_serial_a_paralelo_idle_sync;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         CC    = 4;

  logic clk32f = 1'b0;
  logic reset  = 1'b1;

  serial_a_paralelo_idle_sync_if bif ();

  serial_a_paralelo_idle_sync #(
    .COMMA       (COMMA),
    .COMMA_COUNT (CC)
  ) dut (
    .clk32f (clk32f),
    .reset  (reset),
    .bus    (bif)
  );

  always #5 clk32f = ~clk32f;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole bit history since reset; alignment tracked as the bit
  // index where the hunted comma ended, boundaries are multiples of 8 from it.
  bit         m_hist[$];
  int         m_n, m_mode, m_align, m_run, m_idx;
  logic [7:0] m_byte;
  logic [7:0] m_data;
  logic       m_valid, m_comma, m_active;

  always @(posedge clk32f or posedge reset) begin
    if (reset) begin
      m_hist.delete();
      m_n = 0; m_mode = 0; m_align = 0; m_run = 0;
      m_data = 8'h00; m_valid = 1'b0; m_comma = 1'b0; m_active = 1'b0;
    end else begin
      m_hist.push_back(bif.in_serial);
      m_n++;
      m_byte = 8'h00;
      for (int k = 0; k < 8; k++) begin
        m_idx  = m_n - 8 + k;
        m_byte = {m_byte[6:0], (m_idx >= 0) ? m_hist[m_idx] : 1'b0};
      end
      m_valid = 1'b0;
      m_comma = 1'b0;
      if (m_mode == 0) begin
        if (m_byte == COMMA) begin
          m_mode = 1; m_align = m_n; m_run = 1;
        end
      end else if ((m_n - m_align) % 8 == 0) begin
        if (m_mode == 1) begin
          if (m_byte == COMMA) begin
            m_run++;
            if (m_run == CC) begin m_mode = 2; m_active = 1'b1; end
          end else begin
            m_mode = 0; m_run = 0;
          end
        end else begin
          m_data = m_byte;
          if (m_byte == COMMA) m_comma = 1'b1; else m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk32f) begin
    if (chk_en) begin
      check("data_out",  bif.data_out,  m_data);
      check("valid_out", bif.valid_out, m_valid);
      check("comma_out", bif.comma_out, m_comma);
      check("active",    bif.active,    m_active);
      check("strobe_excl", bif.valid_out & bif.comma_out, 1'b0);
    end
  end

  int         bits_sent;
  int         lock_bit;
  int         comma_pulses;
  int         vq_bit[$];
  logic [7:0] vq_dat[$];

  task automatic send_bit(input logic b);
    bif.in_serial = b;
    @(posedge clk32f);
    #1;
    bits_sent++;
    if (lock_bit < 0 && bif.active === 1'b1) lock_bit = bits_sent;
    if (bif.valid_out === 1'b1) begin
      vq_bit.push_back(bits_sent);
      vq_dat.push_back(bif.data_out);
    end
    if (bif.comma_out === 1'b1) comma_pulses++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic clear_obs();
    bits_sent = 0; lock_bit = -1; comma_pulses = 0;
    vq_bit.delete(); vq_dat.delete();
  endtask

  // Reset lands between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk32f);
    #2 reset = 1'b1;
    #1;
    check("rst_data_out",  bif.data_out,  8'h00);
    check("rst_valid_out", bif.valid_out, 1'b0);
    check("rst_comma_out", bif.comma_out, 1'b0);
    check("rst_active",    bif.active,    1'b0);
    repeat (2) @(negedge clk32f);
    reset = 1'b0;
    clear_obs();
  endtask

  int         n_nc;
  logic [7:0] rb;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.in_serial = 1'b0;
    clear_obs();
    repeat (2) @(negedge clk32f);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Comma run at every bit phase: lock latency is fixed at 24 bits.
    for (int off = 0; off < 8; off++) begin
      do_reset();
      repeat (off) send_bit(1'b0);
      repeat (6) send_byte(COMMA);
      check($sformatf("lock_latency_off%0d", off), lock_bit - (off + 8), 24);
      check($sformatf("comma_pulses_off%0d", off), comma_pulses, 2);
      check($sformatf("no_valid_off%0d", off), vq_bit.size(), 0);
    end

    // Data after lock at phase 3: 0x55, comma, 0xA3.
    do_reset();
    repeat (3) send_bit(1'b0);
    repeat (5) send_byte(COMMA);
    check("model_locked", m_active, 1'b1);
    send_byte(8'h55);
    send_byte(COMMA);
    check("hold_comma_data", bif.data_out, 8'hBC);
    send_byte(8'hA3);
    send_byte(COMMA);
    check("valid_count", vq_bit.size(), 2);
    if (vq_bit.size() == 2) begin
      check("valid0_data", vq_dat[0], 8'h55);
      check("valid1_data", vq_dat[1], 8'hA3);
      check("valid0_bit",  vq_bit[0], 51);
      check("valid_gap",   vq_bit[1] - vq_bit[0], 16);
    end
    check("comma_pulses_t3", comma_pulses, 3);

    // Random bytes while locked: every non-comma byte yields exactly one strobe.
    clear_obs();
    n_nc = 0;
    for (int i = 0; i < 30; i++) begin
      rb = 8'($urandom_range(255, 0));
      if (rb != COMMA) n_nc++;
      send_byte(rb);
    end
    check("random_valid_count", vq_bit.size(), n_nc);

    // Broken run before lock, then a clean run.
    do_reset();
    send_byte(COMMA);
    send_byte(COMMA);
    send_byte(8'h00);
    check("broken_run_inactive", bif.active, 1'b0);
    repeat (4) send_byte(COMMA);
    check("relock_active", bif.active, 1'b1);
    check("relock_bit", lock_bit, 56);

    // False comma straddling a boundary, killed by a non-comma, then real commas.
    do_reset();
    repeat ($urandom_range(7, 1)) send_bit(1'($urandom_range(1, 0)));
    send_byte(COMMA);
    send_byte(8'h0F);
    check("false_comma_inactive", bif.active, 1'b0);
    repeat (6) send_byte(COMMA);
    check("genuine_lock", bif.active, 1'b1);
    send_byte(8'hA5);
    check("phase_valid", bif.valid_out, 1'b1);
    check("phase_data",  bif.data_out,  8'hA5);

    // Comma-heavy random stream at a random phase.
    do_reset();
    repeat ($urandom_range(20, 0)) send_bit(1'($urandom_range(1, 0)));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9, 0) < 7) send_byte(COMMA);
      else send_byte(8'($urandom_range(255, 0)));
    end
    repeat (200) send_bit(1'($urandom_range(1, 0)));

    @(negedge clk32f);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
